// File: rtl/sb_pkg.sv
// Shared types for the post-commit store drain buffer.
//   sb_entry_t : one buffered store (valid, word address, data, byte enables)
//   sb_state_t : drain FSM state
// Entry field widths are fixed here. The DATA_WIDTH/ADDR_WIDTH parameters of
// store_drain_buffer must match SB_DATA_W/SB_ADDR_W.
package sb_pkg;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_BE_W   = SB_DATA_W / 8;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;   // word address, byte-offset bits held at zero
        logic [SB_DATA_W-1:0] data;
        logic [SB_BE_W-1:0]   be;
    } sb_entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } sb_state_t;
endpackage

// File: rtl/sb_fwd_match.sv
// Combinational youngest-match search over the store buffer entries.
// Ports:
//   entries    : full entry array
//   tail       : next allocation slot; tail-1 is the youngest entry
//   probe_addr : load byte address; only the word part is compared
//   hit/data/be: result from the youngest valid matching entry, zero on miss
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int SB_ENTRIES   = 8,
    parameter int SB_PTR_WIDTH = $clog2(SB_ENTRIES)
) (
    input  sb_entry_t               entries [SB_ENTRIES],
    input  logic [SB_PTR_WIDTH-1:0] tail,
    input  logic [SB_ADDR_W-1:0]    probe_addr,
    output logic                    hit,
    output logic [SB_DATA_W-1:0]    data,
    output logic [SB_BE_W-1:0]      be
);
    localparam int OFF = $clog2(SB_BE_W);

    logic [SB_ADDR_W-1:0]    probe_word;
    logic [SB_PTR_WIDTH-1:0] idx;
    logic                    unused_probe_bits;

    assign probe_word        = {probe_addr[SB_ADDR_W-1:OFF], {OFF{1'b0}}};
    assign unused_probe_bits = &{1'b0, probe_addr[OFF-1:0]};

    // Walk from oldest age to youngest so the youngest match is written last.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        be   = '0;
        idx  = '0;
        for (int k = SB_ENTRIES - 1; k >= 0; k--) begin
            idx = tail - SB_PTR_WIDTH'(k + 1);
            if (entries[idx].valid && (entries[idx].addr == probe_word)) begin
                hit  = 1'b1;
                data = entries[idx].data;
                be   = entries[idx].be;
            end
        end
    end
endmodule

// File: rtl/store_drain_buffer.sv
// Post-commit store buffer: accepts committed stores, drains them in order to
// the data-memory write port (one outstanding write), and forwards the
// youngest matching store to load probes.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   enq_valid/addr/data/be, enq_ready : store enqueue
//   mem_wr_valid/addr/data/be, mem_wr_ready, mem_wr_ack : memory write port
//   fwd_addr -> fwd_hit/data/be     : combinational forwarding probe
//   count, full, empty              : occupancy
// Optional feature macro: SB_COALESCE_EN merges an enqueue into the youngest
// entry when it targets the same word and that entry is not being drained.
//
// state    | meaning
// IDLE     | no write in flight; leaves when buffer is non-empty
// REQ      | presenting head entry to memory, waiting for mem_wr_ready
// WAIT_ACK | write accepted, waiting for mem_wr_ack to pop the head
module store_drain_buffer
    import sb_pkg::*;
#(
    parameter int SB_ENTRIES   = 8,
    parameter int SB_PTR_WIDTH = $clog2(SB_ENTRIES),
    parameter int DATA_WIDTH   = SB_DATA_W,
    parameter int ADDR_WIDTH   = SB_ADDR_W,
    parameter int BE_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enq_valid,
    input  logic [ADDR_WIDTH-1:0]   enq_addr,
    input  logic [DATA_WIDTH-1:0]   enq_data,
    input  logic [BE_WIDTH-1:0]     enq_be,
    output logic                    enq_ready,
    output logic                    mem_wr_valid,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic [BE_WIDTH-1:0]     mem_wr_be,
    input  logic                    mem_wr_ready,
    input  logic                    mem_wr_ack,
    input  logic [ADDR_WIDTH-1:0]   fwd_addr,
    output logic                    fwd_hit,
    output logic [DATA_WIDTH-1:0]   fwd_data,
    output logic [BE_WIDTH-1:0]     fwd_be,
    output logic [SB_PTR_WIDTH:0]   count,
    output logic                    full,
    output logic                    empty
);
    localparam int OFF = $clog2(BE_WIDTH);
    localparam logic [SB_PTR_WIDTH:0] FULL_CNT = (SB_PTR_WIDTH + 1)'(SB_ENTRIES);

    sb_entry_t               entries [SB_ENTRIES];
    sb_entry_t               head_e;
    sb_state_t               state, state_nxt;
    logic [SB_PTR_WIDTH-1:0] head, tail;
    logic [SB_PTR_WIDTH:0]   cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0]   enq_word;
    logic                    merge_ok, merge, alloc, pop;
    logic                    unused_enq_bits;

    assign enq_word        = {enq_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    assign unused_enq_bits = &{1'b0, enq_addr[OFF-1:0]};
    assign head_e          = entries[head];

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign count = cnt;

`ifdef SB_COALESCE_EN
    logic [SB_PTR_WIDTH-1:0] last;
    assign last = tail - SB_PTR_WIDTH'(1);
    // The head is frozen once the FSM has started presenting it.
    assign merge_ok = entries[last].valid && (entries[last].addr == enq_word)
                      && !((state != IDLE) && (last == head));
`else
    assign merge_ok = 1'b0;
`endif

    // A merge needs no slot, so it is accepted even when full.
    assign enq_ready = !full || merge_ok;
    assign merge     = enq_valid && merge_ok;
    assign alloc     = enq_valid && !full && !merge_ok;
    assign pop       = (state == WAIT_ACK) && mem_wr_ack;
    assign cnt_nxt   = cnt + {{SB_PTR_WIDTH{1'b0}}, alloc} - {{SB_PTR_WIDTH{1'b0}}, pop};

    always_comb begin
        state_nxt    = state;
        mem_wr_valid = 1'b0;
        case (state)
            IDLE:     if (!empty) state_nxt = REQ;
            REQ: begin
                mem_wr_valid = 1'b1;
                if (mem_wr_ready) state_nxt = WAIT_ACK;
            end
            WAIT_ACK: if (mem_wr_ack) state_nxt = (cnt_nxt != '0) ? REQ : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign mem_wr_addr = mem_wr_valid ? head_e.addr : '0;
    assign mem_wr_data = mem_wr_valid ? head_e.data : '0;
    assign mem_wr_be   = mem_wr_valid ? head_e.be   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            for (int i = 0; i < SB_ENTRIES; i++) entries[i] <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // pop and alloc never target the same slot: alloc needs !full, pop needs cnt > 0
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + SB_PTR_WIDTH'(1);
            end
            if (alloc) begin
                entries[tail] <= {1'b1, enq_word, enq_data, enq_be};
                tail          <= tail + SB_PTR_WIDTH'(1);
            end
`ifdef SB_COALESCE_EN
            if (merge) begin
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (enq_be[b]) entries[last].data[8*b +: 8] <= enq_data[8*b +: 8];
                end
                entries[last].be <= entries[last].be | enq_be;
            end
`endif
        end
    end

    sb_fwd_match #(
        .SB_ENTRIES   (SB_ENTRIES),
        .SB_PTR_WIDTH (SB_PTR_WIDTH)
    ) u_fwd (
        .entries    (entries),
        .tail       (tail),
        .probe_addr (fwd_addr),
        .hit        (fwd_hit),
        .data       (fwd_data),
        .be         (fwd_be)
    );
endmodule

// File: tb/tb_store_drain_buffer.sv
module tb_store_drain_buffer;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enq_valid;
    logic [31:0] enq_addr, enq_data;
    logic [3:0]  enq_be;
    logic        enq_ready;
    logic        mem_wr_valid;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic        mem_wr_ready, mem_wr_ack;
    logic [31:0] fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_be;
    logic [3:0]  count;
    logic        full, empty;

    always #5 clk = ~clk;

    store_drain_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data), .enq_be(enq_be),
        .enq_ready(enq_ready),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_be(mem_wr_be), .mem_wr_ready(mem_wr_ready), .mem_wr_ack(mem_wr_ack),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_be(fwd_be),
        .count(count), .full(full), .empty(empty)
    );

    // Reference model: ordered list of buffered stores plus drain-engine status.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } st_t;
    st_t mq[$];
    bit  busy;   // drain engine has picked up the head (presenting or awaiting ack)
    bit  outst;  // a write has been accepted by memory and awaits its ack
    int  n_checks, n_fail;

    function automatic bit m_merge_ok(input logic [31:0] a);
`ifdef SB_COALESCE_EN
        if (mq.size() == 0) return 1'b0;
        if (mq[mq.size()-1].addr[31:2] != a[31:2]) return 1'b0;
        if (mq.size() == 1 && busy) return 1'b0;
        return 1'b1;
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic bit m_ready();
        return (mq.size() < N) || m_merge_ok(enq_addr);
    endfunction

    function automatic void m_fwd(input logic [31:0] a, output bit h,
                                  output logic [31:0] d, output logic [3:0] b);
        h = 1'b0; d = '0; b = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].addr[31:2] == a[31:2]) begin
                h = 1'b1; d = mq[i].data; b = mq[i].be;
                break;
            end
        end
    endfunction

    function automatic void m_clear();
        mq.delete();
        busy  = 1'b0;
        outst = 1'b0;
    endfunction

    // Called at the falling edge with inputs stable; advances the model over
    // the next rising edge and returns at rising edge + 1.
    task automatic tick();
        bit mrg, acc, pop, hs;
        int sz_pre;
        st_t t;
        sz_pre = mq.size();
        mrg = enq_valid && m_merge_ok(enq_addr);
        acc = enq_valid && (mq.size() < N) && !mrg;
        pop = outst && mem_wr_ack;
        hs  = busy && !outst && mem_wr_ready;
        @(posedge clk); #1;
        if (pop) begin
            void'(mq.pop_front());
            outst = 1'b0;
        end
        if (hs) outst = 1'b1;
        if (mrg) begin
            t = mq[mq.size()-1];
            for (int b = 0; b < 4; b++) if (enq_be[b]) t.data[8*b +: 8] = enq_data[8*b +: 8];
            t.be = t.be | enq_be;
            mq[mq.size()-1] = t;
        end
        if (acc) begin
            t.addr = enq_addr; t.data = enq_data; t.be = enq_be;
            mq.push_back(t);
        end
        if (busy) busy = !(pop && mq.size() == 0);
        else      busy = (sz_pre > 0);
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        enq_valid = 1'b1; enq_addr = a; enq_data = d; enq_be = b;
        @(negedge clk);
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        fwd_addr = 32'h0;
        #2;
        n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b want 0", mem_wr_valid); end
        n_checks++; if ({mem_wr_addr, mem_wr_data, mem_wr_be} !== 68'h0) begin n_fail++; $display("FAIL reset_wr_fields: got %h/%h/%h want 0", mem_wr_addr, mem_wr_data, mem_wr_be); end
        n_checks++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_hit: got %b want 0", fwd_hit); end
        @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        enq(32'h100, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        n_checks++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_n1_valid: got %b want 0", mem_wr_valid); end
        tick();
        mem_wr_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_wr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_n2_valid: got %b want 1", mem_wr_valid); end
        n_checks++; if (mem_wr_addr !== 32'h100) begin n_fail++; $display("FAIL basic_addr: got %h want 00000100", mem_wr_addr); end
        n_checks++; if (mem_wr_data !== 32'hDEADBEEF || mem_wr_be !== 4'hF) begin n_fail++; $display("FAIL basic_data: got %h/%h want deadbeef/f", mem_wr_data, mem_wr_be); end
        tick();
        mem_wr_ready = 1'b0; mem_wr_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait_valid: got %b want 0", mem_wr_valid); end
        tick();
        mem_wr_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (empty !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL basic_empty: got empty=%b count=%0d want 1/0", empty, count); end
        tick();
    endtask

    task automatic drain_all(input string tag);
        int guard = 0;
        enq_valid = 1'b0;
        while (mq.size() > 0 && guard < 400) begin
            mem_wr_ready = 1'($urandom % 2);
            mem_wr_ack   = outst ? 1'($urandom % 2) : 1'b0;
            @(negedge clk);
            n_checks++; if (mem_wr_valid !== (busy && !outst)) begin n_fail++; $display("FAIL %s_drain_valid: got %b want %b", tag, mem_wr_valid, busy && !outst); end
            if (busy && !outst) begin
                n_checks++;
                if (mem_wr_addr !== {mq[0].addr[31:2], 2'b00} || mem_wr_data !== mq[0].data || mem_wr_be !== mq[0].be) begin
                    n_fail++;
                    $display("FAIL %s_drain_fields: got %h/%h/%h want %h/%h/%h", tag, mem_wr_addr, mem_wr_data, mem_wr_be, {mq[0].addr[31:2], 2'b00}, mq[0].data, mq[0].be);
                end
            end
            n_checks++; if (count !== 4'(mq.size())) begin n_fail++; $display("FAIL %s_drain_count: got %0d want %0d", tag, count, mq.size()); end
            tick();
            guard++;
        end
        mem_wr_ready = 1'b0; mem_wr_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (mq.size() != 0 || count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL %s_drain_done: got count=%0d empty=%b left=%0d want 0/1/0", tag, count, empty, mq.size()); end
        tick();
    endtask

    task automatic test_fill();
        mem_wr_ready = 1'b0; mem_wr_ack = 1'b0;
        for (int i = 0; i < N; i++) enq(32'h1000 + 32'(4 * i), $urandom, 4'($urandom_range(1, 15)));
        enq_valid = 1'b1; enq_addr = 32'h2000; enq_data = 32'h99999999; enq_be = 4'hF;
        @(negedge clk);
        n_checks++; if (full !== 1'b1 || enq_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got full=%b ready=%b want 1/0", full, enq_ready); end
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d want 8", count); end
        tick();
        enq_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_ninth: got %0d want 8", count); end
        tick();
        drain_all("fill");
    endtask

    task automatic test_fwd();
        mem_wr_ready = 1'b0;
        enq(32'h200, 32'h11111111, 4'hF);
        enq(32'h204, 32'h22222222, 4'hF);
        enq(32'h200, 32'h33333333, 4'h3);
        fwd_addr = 32'h202;
        @(negedge clk);
        n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h33333333 || fwd_be !== 4'h3) begin n_fail++; $display("FAIL fwd_youngest: got %b/%h/%h want 1/33333333/3", fwd_hit, fwd_data, fwd_be); end
        tick();
        fwd_addr = 32'h300;
        @(negedge clk);
        n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0 || fwd_be !== 4'h0) begin n_fail++; $display("FAIL fwd_miss: got %b/%h/%h want 0/0/0", fwd_hit, fwd_data, fwd_be); end
        tick();
        fwd_addr = 32'h207;
        @(negedge clk);
        n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22222222 || fwd_be !== 4'hF) begin n_fail++; $display("FAIL fwd_mid: got %b/%h/%h want 1/22222222/f", fwd_hit, fwd_data, fwd_be); end
        tick();
        drain_all("fwd");
    endtask

    task automatic test_full_ack();
        mem_wr_ready = 1'b0; mem_wr_ack = 1'b0;
        for (int i = 0; i < N; i++) enq(32'h3000 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
        mem_wr_ready = 1'b1;
        @(negedge clk); tick();
        mem_wr_ready = 1'b0;
        mem_wr_ack = 1'b1;
        enq_valid = 1'b1; enq_addr = 32'h3100; enq_data = 32'hBAD0BAD0; enq_be = 4'hF;
        @(negedge clk);
        n_checks++; if (enq_ready !== 1'b0 || count !== 4'd8) begin n_fail++; $display("FAIL fullack_reject: got ready=%b count=%0d want 0/8", enq_ready, count); end
        tick();
        mem_wr_ack = 1'b0;
        enq_addr = 32'h3200; enq_data = 32'h600D600D;
        @(negedge clk);
        n_checks++; if (enq_ready !== 1'b1 || count !== 4'd7) begin n_fail++; $display("FAIL fullack_after_pop: got ready=%b count=%0d want 1/7", enq_ready, count); end
        tick();
        enq_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (count !== 4'd8 || full !== 1'b1) begin n_fail++; $display("FAIL fullack_count: got %0d full=%b want 8/1", count, full); end
        tick();
        drain_all("fullack");
    endtask

    task automatic test_reset_mid();
        mem_wr_ready = 1'b0; mem_wr_ack = 1'b0;
        for (int i = 0; i < 3; i++) enq(32'h5000 + 32'(4 * i), $urandom, 4'hF);
        mem_wr_ready = 1'b1;
        @(negedge clk); tick();
        mem_wr_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (count !== 4'd3 || mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre: got count=%0d valid=%b want 3/0", count, mem_wr_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (count !== 4'd0 || empty !== 1'b1 || mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got count=%0d empty=%b valid=%b want 0/1/0", count, empty, mem_wr_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        @(posedge clk); #1;
        mem_wr_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (count !== 4'd0 || mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_ack: got count=%0d valid=%b want 0/0", count, mem_wr_valid); end
        tick();
        mem_wr_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (count !== 4'd0 || mem_wr_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle: got count=%0d valid=%b empty=%b want 0/0/1", count, mem_wr_valid, empty); end
            tick();
        end
    endtask

`ifdef SB_COALESCE_EN
    task automatic test_coalesce();
        mem_wr_ready = 1'b0; mem_wr_ack = 1'b0;
        enq(32'h400, 32'hAABBCCDD, 4'hF);
        enq_valid = 1'b1; enq_addr = 32'h400; enq_data = 32'h000000EE; enq_be = 4'h1;
        @(negedge clk);
        n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL coal_ready: got %b want 1", enq_ready); end
        tick();
        enq_valid = 1'b0; fwd_addr = 32'h400;
        @(negedge clk);
        n_checks++; if (count !== 4'd1 || fwd_data !== 32'hAABBCCEE || fwd_be !== 4'hF) begin n_fail++; $display("FAIL coal_merge: got count=%0d data=%h be=%h want 1/aabbccee/f", count, fwd_data, fwd_be); end
        n_checks++; if (mem_wr_valid !== 1'b1 || mem_wr_data !== 32'hAABBCCEE) begin n_fail++; $display("FAIL coal_req: got %b/%h want 1/aabbccee", mem_wr_valid, mem_wr_data); end
        tick();
        enq(32'h400, 32'h000000FF, 4'h1);
        @(negedge clk);
        n_checks++; if (count !== 4'd2 || fwd_data !== 32'h000000FF || fwd_be !== 4'h1) begin n_fail++; $display("FAIL coal_head_busy: got count=%0d data=%h be=%h want 2/000000ff/1", count, fwd_data, fwd_be); end
        n_checks++; if (mem_wr_data !== 32'hAABBCCEE) begin n_fail++; $display("FAIL coal_head_stable: got %h want aabbccee", mem_wr_data); end
        tick();
        drain_all("coal");
    endtask
`endif

    task automatic test_random();
        bit          eh;
        logic [31:0] ed;
        logic [3:0]  eb;
        int          uniq = 0;
        for (int c = 0; c < 800; c++) begin
            enq_valid = ($urandom % 3) != 0;
`ifdef SB_COALESCE_EN
            enq_addr = 32'h8000 + 32'(uniq * 4) + 32'($urandom % 4);
            uniq++;
`else
            enq_addr = 32'(($urandom % 4) * 4) + 32'($urandom % 4);
`endif
            enq_data     = $urandom;
            enq_be       = 4'($urandom_range(1, 15));
            mem_wr_ready = 1'($urandom % 2);
            mem_wr_ack   = outst ? 1'(($urandom % 3) == 0) : 1'(($urandom % 8) == 0);
            if (mq.size() > 0 && ($urandom % 2) == 1)
                fwd_addr = {mq[$urandom % mq.size()].addr[31:2], 2'($urandom % 4)};
            else
                fwd_addr = 32'(($urandom % 6) * 4) + 32'($urandom % 4);
            @(negedge clk);
            m_fwd(fwd_addr, eh, ed, eb);
            n_checks++; if (count !== 4'(mq.size()) || full !== (mq.size() == N) || empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rand_occ c%0d: got count=%0d full=%b empty=%b want %0d", c, count, full, empty, mq.size()); end
            n_checks++; if (enq_ready !== m_ready()) begin n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, enq_ready, m_ready()); end
            n_checks++; if (fwd_hit !== eh || fwd_data !== ed || fwd_be !== eb) begin n_fail++; $display("FAIL rand_fwd c%0d: got %b/%h/%h want %b/%h/%h", c, fwd_hit, fwd_data, fwd_be, eh, ed, eb); end
            n_checks++; if (mem_wr_valid !== (busy && !outst)) begin n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, mem_wr_valid, busy && !outst); end
            if (busy && !outst) begin
                n_checks++;
                if (mem_wr_addr !== {mq[0].addr[31:2], 2'b00} || mem_wr_data !== mq[0].data || mem_wr_be !== mq[0].be) begin
                    n_fail++;
                    $display("FAIL rand_fields c%0d: got %h/%h/%h want %h/%h/%h", c, mem_wr_addr, mem_wr_data, mem_wr_be, {mq[0].addr[31:2], 2'b00}, mq[0].data, mq[0].be);
                end
            end
            tick();
        end
        drain_all("rand");
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        busy = 1'b0; outst = 1'b0;
        rst_n = 1'b0;
        enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_be = '0;
        mem_wr_ready = 1'b0; mem_wr_ack = 1'b0; fwd_addr = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_fill();
        test_fwd();
        test_full_ack();
        test_reset_mid();
`ifdef SB_COALESCE_EN
        test_coalesce();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end
endmodule
